mem_port_arbiter: RTL and testbench

- Shares the single external memory port between the instruction-cache controller and the data-cache controller.
- Each cache controller issues line transactions of BEATS 32-bit beats (line fill or write-back). The arbiter grants one controller at a time and holds the grant for the full transaction.
- Muxes the owner's request onto the memory port and routes memory ready/data back only to the owner.
- Sits between the two cache controllers and the memory model/controller.

---
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter (icache / dcache) holding the grant for a BEATS-long line transaction.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; default is fixed dcache priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int BEATS  = 2
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req_valid,
    input  logic              i_req_rw,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_data,
    output logic              i_rsp_ready,
    output logic [DATA_W-1:0] i_rsp_data,

    input  logic              d_req_valid,
    input  logic              d_req_rw,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_data,
    output logic              d_rsp_ready,
    output logic [DATA_W-1:0] d_rsp_data,

    output logic              mem_valid,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic [1:0]        owner
);

`ifdef MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS);

    // Encoding doubles as the debug owner code.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
    logic [CNT_W-1:0] beat_cnt_inc;
    logic             last_is_d, last_is_d_nxt;
    logic             own_valid;

    assign beat_cnt_inc = beat_cnt + CNT_W'(1);
    assign owner        = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            last_is_d <= 1'b0;
        end else begin
            state     <= state_nxt;
            beat_cnt  <= beat_cnt_nxt;
            last_is_d <= last_is_d_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        beat_cnt_nxt  = beat_cnt;
        last_is_d_nxt = last_is_d;
        own_valid     = 1'b0;
        mem_valid     = 1'b0;
        mem_rw        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        i_rsp_ready   = 1'b0;
        i_rsp_data    = '0;
        d_rsp_ready   = 1'b0;
        d_rsp_data    = '0;

        unique case (state)
            IDLE: begin
                // RR_EN is constant; with it clear, contention always resolves to dcache.
                if (i_req_valid && d_req_valid)
                    state_nxt = (RR_EN && last_is_d) ? GRANT_I : GRANT_D;
                else if (d_req_valid)
                    state_nxt = GRANT_D;
                else if (i_req_valid)
                    state_nxt = GRANT_I;
            end
            GRANT_I: begin
                own_valid   = i_req_valid;
                mem_valid   = i_req_valid;
                mem_rw      = i_req_rw;
                mem_addr    = i_req_addr;
                mem_wdata   = i_req_data;
                i_rsp_ready = mem_ready;
                i_rsp_data  = mem_rdata;
            end
            GRANT_D: begin
                own_valid   = d_req_valid;
                mem_valid   = d_req_valid;
                mem_rw      = d_req_rw;
                mem_addr    = d_req_addr;
                mem_wdata   = d_req_data;
                d_rsp_ready = mem_ready;
                d_rsp_data  = mem_rdata;
            end
            default: state_nxt = IDLE;
        endcase

        // A beat that lands while the owner drops valid still counts; abort only on a quiet cycle.
        if (state == GRANT_I || state == GRANT_D) begin
            if (mem_ready) begin
                if (beat_cnt_inc == LAST_BEAT) begin
                    beat_cnt_nxt  = '0;
                    last_is_d_nxt = (state == GRANT_D);
                    state_nxt     = IDLE;
                end else begin
                    beat_cnt_nxt = beat_cnt_inc;
                end
            end else if (!own_valid) begin
                beat_cnt_nxt = '0;
                state_nxt    = IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios then random traffic against a cycle model.
// Honours MEM_ARB_RR_EN so the same bench serves both builds.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int BEATS  = 2;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              i_req_valid, i_req_rw;
    logic [ADDR_W-1:0] i_req_addr;
    logic [DATA_W-1:0] i_req_data;
    logic              i_rsp_ready;
    logic [DATA_W-1:0] i_rsp_data;
    logic              d_req_valid, d_req_rw;
    logic [ADDR_W-1:0] d_req_addr;
    logic [DATA_W-1:0] d_req_data;
    logic              d_rsp_ready;
    logic [DATA_W-1:0] d_rsp_data;
    logic              mem_valid, mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        owner;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_rw(i_req_rw), .i_req_addr(i_req_addr),
        .i_req_data(i_req_data), .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data),
        .d_req_valid(d_req_valid), .d_req_rw(d_req_rw), .d_req_addr(d_req_addr),
        .d_req_data(d_req_data), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
        .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: who holds the port (0 none, 1 icache, 2 dcache), beats delivered, last finisher.
    int cur  = 0;
    int done = 0;
    int last = 1;

    int          i_pulses = 0, d_pulses = 0;
    logic [31:0] i_last_data, d_last_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic exp_mv;
        exp_mv = (cur == 1) ? i_req_valid : (cur == 2) ? d_req_valid : 1'b0;
        chk("owner", 32'(owner), 32'(cur));
        chk("mem_valid", 32'(mem_valid), 32'(exp_mv));
        chk("i_rsp_ready", 32'(i_rsp_ready), 32'(cur == 1 && mem_ready));
        chk("d_rsp_ready", 32'(d_rsp_ready), 32'(cur == 2 && mem_ready));
        chk("i_rsp_data", i_rsp_data, (cur == 1) ? mem_rdata : 32'h0);
        chk("d_rsp_data", d_rsp_data, (cur == 2) ? mem_rdata : 32'h0);
        if (cur == 1) begin
            chk("mem_rw_i", 32'(mem_rw), 32'(i_req_rw));
            chk("mem_addr_i", 32'(mem_addr), 32'(i_req_addr));
            chk("mem_wdata_i", mem_wdata, i_req_data);
        end else if (cur == 2) begin
            chk("mem_rw_d", 32'(mem_rw), 32'(d_req_rw));
            chk("mem_addr_d", 32'(mem_addr), 32'(d_req_addr));
            chk("mem_wdata_d", mem_wdata, d_req_data);
        end
    endtask

    task automatic model_update();
        bit own;
        if (rst) begin
            cur = 0; done = 0; last = 1;
        end else if (cur == 0) begin
            if (i_req_valid && d_req_valid) cur = RR ? (3 - last) : 2;
            else if (d_req_valid)           cur = 2;
            else if (i_req_valid)           cur = 1;
        end else begin
            own = (cur == 1) ? i_req_valid : d_req_valid;
            if (mem_ready) begin
                done++;
                if (done == BEATS) begin
                    last = cur; cur = 0; done = 0;
                end
            end else if (!own) begin
                cur = 0; done = 0;
            end
        end
    endtask

    // Inputs are set at posedge+1; outputs are checked at posedge+4, then the model advances.
    task automatic cycle();
        #3;
        check_outputs();
        if (i_rsp_ready === 1'b1) begin i_pulses++; i_last_data = i_rsp_data; end
        if (d_rsp_ready === 1'b1) begin d_pulses++; d_last_data = d_rsp_data; end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic serve(input int n, input bit drop);
        int w;
        w = cur;
        for (int b = 0; b < n; b++) begin
            mem_ready = 1'b0; cycle();
            mem_ready = 1'b1; mem_rdata = $urandom; cycle();
        end
        mem_ready = 1'b0;
        if (drop) begin
            if (w == 1) i_req_valid = 1'b0;
            else if (w == 2) d_req_valid = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        i_req_valid = 0; i_req_rw = 0; i_req_addr = '0; i_req_data = '0;
        d_req_valid = 0; d_req_rw = 0; d_req_addr = '0; d_req_data = '0;
        mem_ready = 0; mem_rdata = '0;
        @(posedge clk);
        model_update();
        #1;

        // Reset held with both requesting; dcache granted one cycle after release.
        i_req_valid = 1; i_req_addr = 16'h0100;
        d_req_valid = 1; d_req_addr = 16'h0200;
        cycle(); cycle();
        rst = 1'b0;
        i_req_valid = 0;
        cycle();
        chk("post_reset_owner", 32'(owner), 32'h2);
        serve(BEATS, 1'b1);
        cycle();

        // Contention after a dcache transaction.
        i_req_valid = 1; i_req_rw = 0; i_req_addr = 16'h0300;
        d_req_valid = 1; d_req_rw = 0; d_req_addr = 16'h0400;
        cycle();
        chk("contention_first", 32'(owner), RR ? 32'h1 : 32'h2);
        serve(BEATS, 1'b1);
        cycle();
        chk("contention_second", 32'(owner), RR ? 32'h2 : 32'h1);
        serve(BEATS, 1'b1);
        cycle();
        chk("contention_idle", 32'(owner), 32'h0);

        // Single icache read with fixed data.
        i_pulses = 0; d_pulses = 0;
        i_req_valid = 1; i_req_rw = 0; i_req_addr = 16'h0040;
        cycle();
        cycle();
        mem_ready = 1; mem_rdata = 32'h11112222; cycle();
        chk("i_beat1_data", i_last_data, 32'h11112222);
        mem_ready = 0; cycle();
        mem_ready = 1; mem_rdata = 32'h33334444; cycle();
        chk("i_beat2_data", i_last_data, 32'h33334444);
        mem_ready = 0; i_req_valid = 0;
        chk("i_read_done_owner", 32'(owner), 32'h0);
        cycle();
        chk("i_read_pulses", 32'(i_pulses), 32'd2);
        chk("i_read_d_pulses", 32'(d_pulses), 32'd0);

        // Dirty miss: dcache write-back then fill, icache also waiting (last owner is icache).
        d_req_valid = 1; d_req_rw = 1; d_req_addr = 16'h1230; d_req_data = 32'hDEADBEEF;
        i_req_valid = 1; i_req_rw = 0; i_req_addr = 16'h0080;
        cycle();
        chk("dirty_wb_owner", 32'(owner), 32'h2);
        serve(BEATS, 1'b0);
        d_req_rw = 0; d_req_addr = 16'h5630;
        cycle();
        chk("dirty_between_owner", 32'(owner), RR ? 32'h1 : 32'h2);
        serve(BEATS, 1'b1);
        cycle();
        chk("dirty_third_owner", 32'(owner), RR ? 32'h2 : 32'h1);
        serve(BEATS, 1'b1);
        cycle();
        chk("dirty_done_owner", 32'(owner), 32'h0);

        // Abort after one beat, then a full transaction.
        d_pulses = 0;
        d_req_valid = 1; d_req_rw = 0; d_req_addr = 16'h2000;
        cycle();
        cycle();
        mem_ready = 1; mem_rdata = 32'hA5A5A5A5; cycle();
        mem_ready = 0; d_req_valid = 0;
        #3 chk("abort_mem_valid", 32'(mem_valid), 32'h0);
        #1;
        @(posedge clk);
        model_update();
        #1;
        chk("abort_owner", 32'(owner), 32'h0);
        d_req_valid = 1; d_req_addr = 16'h2040;
        cycle();
        serve(BEATS, 1'b1);
        chk("after_abort_owner", 32'(owner), 32'h0);
        cycle();
        chk("abort_pulses", 32'(d_pulses), 32'(1 + BEATS));

        // Reset mid-transaction, stray ready, then a fresh request.
        i_req_valid = 1; i_req_addr = 16'h0500;
        cycle();
        cycle();
        mem_ready = 1; mem_rdata = $urandom; cycle();
        mem_ready = 0; rst = 1; i_req_valid = 0;
        cycle();
        rst = 0; i_pulses = 0; d_pulses = 0;
        mem_ready = 1; mem_rdata = 32'hBAD0BAD0;
        cycle();
        mem_ready = 0;
        chk("stray_i_pulses", 32'(i_pulses), 32'd0);
        chk("stray_d_pulses", 32'(d_pulses), 32'd0);
        i_req_valid = 1; i_req_addr = 16'h0600;
        cycle();
        serve(BEATS, 1'b1);
        cycle();
        chk("fresh_i_pulses", 32'(i_pulses), 32'(BEATS));

        // Random traffic, including aborts, contention and occasional reset.
        for (int c = 0; c < 500; c++) begin
            rst         = ($urandom_range(0, 59) == 0);
            i_req_valid = ($urandom_range(0, 3) != 0);
            d_req_valid = ($urandom_range(0, 3) != 0);
            i_req_rw    = $urandom_range(0, 1);
            d_req_rw    = $urandom_range(0, 1);
            i_req_addr  = ADDR_W'($urandom);
            d_req_addr  = ADDR_W'($urandom);
            i_req_data  = $urandom;
            d_req_data  = $urandom;
            mem_ready   = ($urandom_range(0, 2) == 0);
            mem_rdata   = $urandom;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
